// File: rtl/alu_seq_pkg.sv
// Shared types for the bit-serial ALU slice sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] s;
        logic       m;
        logic       cin;
    } op_t;

endpackage

// File: rtl/alu_seq_shreg.sv
// WIDTH-bit shift register: parallel load, right shift with serial in at the MSB, serial out at the LSB.
module alu_seq_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/alu_serial_sequencer.sv
// Drives a combinational 1-bit ALU slice LSB first and assembles the WIDTH-bit result.
// Optional flags (out_zero, out_ovf) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_serial_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_s,
    input  logic             in_m,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_cout,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             out_zero,
    output logic             out_ovf,
`endif
    output logic             sl_ai,
    output logic             sl_bi,
    output logic             sl_ci,
    output logic             sl_s1,
    output logic             sl_s0,
    output logic             sl_m,
    input  logic             sl_fi,
    input  logic             sl_cout
);

    localparam int IW = $clog2(WIDTH);

    state_t         state, state_nxt;
    op_t            req, op_q;
    logic [IW-1:0]  idx;
    logic           accept, run, last;
    logic           a_bit, b_bit;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] a_unused, b_unused;
    logic           res_sout_unused;

    assign req    = '{s: in_s, m: in_m, cin: in_cin};
    assign accept = in_valid && (state == IDLE);
    assign run    = (state == RUN);
    assign last   = (idx == IW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        sl_ai     = 1'b0;
        sl_bi     = 1'b0;
        sl_ci     = 1'b0;
        if (run) begin
            sl_ai = a_bit;
            sl_bi = b_bit;
            sl_ci = op_q.cin;
        end
    end

    assign sl_s1    = op_q.s[1];
    assign sl_s0    = op_q.s[0];
    assign sl_m     = op_q.m;
    assign out_f    = res_q;
    assign out_cout = op_q.cin;

    // op_q.cin starts as the request carry-in and then serves as the running carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            idx  <= '0;
        end else if (accept) begin
            op_q <= req;
            idx  <= '0;
        end else if (run) begin
            op_q.cin <= sl_cout;
            idx      <= last ? '0 : idx + 1'b1;
        end
    end

    alu_seq_shreg #(.WIDTH(WIDTH)) u_a_sr (
        .clk(clk), .rst(rst), .load(accept), .shift(run), .sin(1'b0),
        .d(in_a), .q(a_unused), .sout(a_bit)
    );

    alu_seq_shreg #(.WIDTH(WIDTH)) u_b_sr (
        .clk(clk), .rst(rst), .load(accept), .shift(run), .sin(1'b0),
        .d(in_b), .q(b_unused), .sout(b_bit)
    );

    // Result bits enter at the MSB, so after WIDTH shifts bit i sits at position i.
    alu_seq_shreg #(.WIDTH(WIDTH)) u_res_sr (
        .clk(clk), .rst(rst), .load(accept), .shift(run), .sin(sl_fi),
        .d('0), .q(res_q), .sout(res_sout_unused)
    );

`ifdef ALU_SEQ_FLAGS_EN
    // Captured on the final RUN edge; op_q.cin there is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (run && last) begin
            out_zero <= ({sl_fi, res_q[WIDTH-1:1]} == '0);
            out_ovf  <= op_q.cin ^ sl_cout;
        end
    end
`endif

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a behavioural slice (m=0 add, m=1 AND).
module tb_alu_serial_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic [1:0]       in_s;
    logic             in_m, in_cin;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_f;
    logic             out_cout;
`ifdef ALU_SEQ_FLAGS_EN
    logic             out_zero, out_ovf;
`endif
    logic             sl_ai, sl_bi, sl_ci, sl_s1, sl_s0, sl_m;
    logic             sl_fi, sl_cout;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    alu_serial_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_cout(out_cout),
`ifdef ALU_SEQ_FLAGS_EN
        .out_zero(out_zero), .out_ovf(out_ovf),
`endif
        .sl_ai(sl_ai), .sl_bi(sl_bi), .sl_ci(sl_ci),
        .sl_s1(sl_s1), .sl_s0(sl_s0), .sl_m(sl_m),
        .sl_fi(sl_fi), .sl_cout(sl_cout)
    );

    always #5 clk = ~clk;

    always_comb begin
        sl_fi   = 1'b0;
        sl_cout = 1'b0;
        if (sl_m) begin
            sl_fi = sl_ai & sl_bi;
        end else begin
            sl_fi   = sl_ai ^ sl_bi ^ sl_ci;
            sl_cout = (sl_ai & sl_bi) | (sl_ai & sl_ci) | (sl_bi & sl_ci);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                        input logic m, input logic cin);
        chk("in_ready before accept", 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_s = s; in_m = m; in_cin = cin;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom);
        in_s = 2'($urandom); in_m = 1'($urandom); in_cin = 1'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("in_ready after retire", 32'(in_ready), 32'd1);
        chk("out_valid after retire", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_s = '0; in_m = 1'b0; in_cin = 1'b0;
        step();
        step();
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_f", 32'(out_f), 32'h00);
        chk("reset out_cout", 32'(out_cout), 32'd0);
        chk("reset sl_*", 32'({sl_ai, sl_bi, sl_ci, sl_s1, sl_s0, sl_m}), 32'd0);
        rst = 1'b0;
        step();

        // 3C + 0F = 4B, latency check
        send(8'h3C, 8'h0F, 2'b00, 1'b0, 1'b0);
        chk("t1 in_ready in RUN", 32'(in_ready), 32'd0);
        chk("t1 out_valid in RUN", 32'(out_valid), 32'd0);
        chk("t1 sl_bi bit0", 32'(sl_bi), 32'd1);
        chk("t1 sl_ai bit0", 32'(sl_ai), 32'd0);
        wait_done(cyc);
        chk("t1 latency", 32'(cyc), 32'd8);
        chk("t1 out_f", 32'(out_f), 32'h4B);
        chk("t1 out_cout", 32'(out_cout), 32'd0);
        retire();

        // FF + 01 = 00 carry 1
        send(8'hFF, 8'h01, 2'b00, 1'b0, 1'b0);
        wait_done(cyc);
        chk("t2 latency", 32'(cyc), 32'd8);
        chk("t2 out_f", 32'(out_f), 32'h00);
        chk("t2 out_cout", 32'(out_cout), 32'd1);
`ifdef ALU_SEQ_FLAGS_EN
        chk("t2 out_zero", 32'(out_zero), 32'd1);
        chk("t2 out_ovf", 32'(out_ovf), 32'd0);
`endif
        retire();

        // 7F + 01 = 80, signed overflow
        send(8'h7F, 8'h01, 2'b00, 1'b0, 1'b0);
        wait_done(cyc);
        chk("t3 out_f", 32'(out_f), 32'h80);
        chk("t3 out_cout", 32'(out_cout), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("t3 out_zero", 32'(out_zero), 32'd0);
        chk("t3 out_ovf", 32'(out_ovf), 32'd1);
`endif
        retire();

        // F0 AND 3C = 30
        send(8'hF0, 8'h3C, 2'b00, 1'b1, 1'b0);
        wait_done(cyc);
        chk("t4 out_f", 32'(out_f), 32'h30);
        chk("t4 out_cout", 32'(out_cout), 32'd0);
        retire();
        chk("t4 sl_m held in idle", 32'(sl_m), 32'd1);
        chk("t4 sl_ai idle", 32'(sl_ai), 32'd0);

        // 12 + 34 = 46, backpressure in DONE
        send(8'h12, 8'h34, 2'b00, 1'b0, 1'b0);
        wait_done(cyc);
        chk("t5 out_f", 32'(out_f), 32'h46);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            in_a = 8'($urandom);
            step();
            chk("t5 hold out_f", 32'(out_f), 32'h46);
            chk("t5 hold in_ready", 32'(in_ready), 32'd0);
            chk("t5 hold out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        retire();
        step();
        chk("t5 no second accept", 32'(out_valid), 32'd0);
        chk("t5 idle in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of RUN at bit 3
        send(8'h55, 8'hAA, 2'b00, 1'b0, 1'b0);
        step(); step(); step();
        chk("t6 sl_bi bit3", 32'(sl_bi), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6 in_ready after rst", 32'(in_ready), 32'd1);
        chk("t6 out_valid after rst", 32'(out_valid), 32'd0);
        chk("t6 out_f after rst", 32'(out_f), 32'h00);
        chk("t6 sl_* after rst", 32'({sl_ai, sl_bi, sl_ci, sl_s1, sl_s0, sl_m}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6 no out_valid after abort", 32'(out_valid), 32'd0);
        end

        // 01 + 02 + cin = 04
        send(8'h01, 8'h02, 2'b00, 1'b0, 1'b1);
        wait_done(cyc);
        chk("t7 latency", 32'(cyc), 32'd8);
        chk("t7 out_f", 32'(out_f), 32'h04);
        chk("t7 out_cout", 32'(out_cout), 32'd0);
        retire();

        // 80 + 80 + cin = 01 carry 1
        send(8'h80, 8'h80, 2'b00, 1'b0, 1'b1);
        wait_done(cyc);
        chk("t8 out_f", 32'(out_f), 32'h01);
        chk("t8 out_cout", 32'(out_cout), 32'd1);
        retire();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
